// File: rtl/cpin_if.sv
// Control panel input link bundle: the received-byte strobe from the UART
// receiver, plus the decoded panel outputs driven by cpin.
interface cpin_if;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [0:15] keys;
  logic [0:3]  rotary_pos;
  logic [0:15] kl;
  logic        trigger;
  logic        cmd_err;

  // Upstream side: supplies bytes and observes the panel actions
  modport master (
    output rx_byte,
    output rx_ready,
    input  keys,
    input  rotary_pos,
    input  kl,
    input  trigger,
    input  cmd_err
  );

  // cpin side: consumes bytes and drives the panel actions
  modport slave (
    input  rx_byte,
    input  rx_ready,
    output keys,
    output rotary_pos,
    output kl,
    output trigger,
    output cmd_err
  );
endinterface

// File: rtl/cpin.sv
// cpin: receive side of the control panel serial link.
// Decodes command bytes into momentary key presses, the rotary switch
// position, the 16-bit data switch word (KL) and a status request trigger.
// KL writes are three-byte commands guarded by an inter-byte timeout.
module cpin #(
  parameter int KEY_CYCLES = 16,
  parameter int TIMEOUT    = 1000000
) (
  input  logic  clk_sys,
  input  logic  rst_n,
  cpin_if.slave bus
);

  // Width that holds TIMEOUT-1, the last idle count before an abort
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [15:0]   KEY_LOAD = 16'(KEY_CYCLES - 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ROT  = 3'b001;
  localparam logic [2:0] OP_KEY  = 3'b010;
  localparam logic [2:0] OP_STAT = 3'b100;
  localparam logic [2:0] OP_KL   = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_HI = 2'd1,
    DATA_LO = 2'd2
  } state_t;

  state_t          state_reg;
  logic [7:0]      hold_reg;
  logic [TW-1:0]   to_cnt_reg;
  logic [0:15]     kl_reg;
  logic [0:3]      rot_reg;
  logic            trig_reg;
  logic            err_reg;
  logic [0:15]     keys_reg;
  logic [15:0]     key_cnt_reg;

  // Command decode (only meaningful for bytes received in IDLE)
  logic [2:0]  opcode;
  logic        sub_zero;
  logic        low_zero;
  logic        cmd_rot;
  logic        cmd_key;
  logic        cmd_stat;
  logic        cmd_kl;
  logic        cmd_bad;
  logic [0:15] key_onehot;

  assign opcode   = bus.rx_byte[7:5];
  assign sub_zero = ~bus.rx_byte[4];
  assign low_zero = (bus.rx_byte[4:0] == 5'd0);

  // Classify the strobed byte; data bytes of a KL write never reach here
  always_comb begin
    cmd_rot  = 1'b0;
    cmd_key  = 1'b0;
    cmd_stat = 1'b0;
    cmd_kl   = 1'b0;
    cmd_bad  = 1'b0;
    if (state_reg == IDLE && bus.rx_ready) begin
      case (opcode)
        OP_NOP:  ;
        OP_ROT:  if (sub_zero) cmd_rot  = 1'b1; else cmd_bad = 1'b1;
        OP_KEY:  if (sub_zero) cmd_key  = 1'b1; else cmd_bad = 1'b1;
        OP_STAT: if (low_zero) cmd_stat = 1'b1; else cmd_bad = 1'b1;
        OP_KL:   if (low_zero) cmd_kl   = 1'b1; else cmd_bad = 1'b1;
        default: cmd_bad = 1'b1;
      endcase
    end
  end

  // One-hot key pattern; index 0 addresses keys[0]
  always_comb begin
    key_onehot = '0;
    key_onehot[bus.rx_byte[3:0]] = 1'b1;
  end

  // Command FSM: rotary/status/error pulses, KL assembly and inter-byte timeout
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      to_cnt_reg <= '0;
      kl_reg     <= '0;
      rot_reg    <= '0;
      trig_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      trig_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          to_cnt_reg <= '0;
          err_reg    <= cmd_bad;
          if (cmd_rot)  rot_reg   <= bus.rx_byte[3:0];
          if (cmd_stat) trig_reg  <= 1'b1;
          if (cmd_kl)   state_reg <= DATA_HI;
        end
        DATA_HI: begin
          // A byte arriving on the deadline cycle still counts
          if (bus.rx_ready) begin
            hold_reg   <= bus.rx_byte;
            to_cnt_reg <= '0;
            state_reg  <= DATA_LO;
          end else if (to_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        DATA_LO: begin
          // Both halves land in the same cycle so kl is never half-written
          if (bus.rx_ready) begin
            kl_reg     <= {hold_reg, bus.rx_byte};
            to_cnt_reg <= '0;
            state_reg  <= IDLE;
          end else if (to_cnt_reg == TO_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          to_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Momentary key pulse: a new key command replaces the current one and
  // restarts the hold; the counter holds the remaining cycles after this one
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      keys_reg    <= '0;
      key_cnt_reg <= '0;
    end else if (cmd_key) begin
      keys_reg    <= key_onehot;
      key_cnt_reg <= KEY_LOAD;
    end else if (keys_reg != '0) begin
      if (key_cnt_reg == 16'd0) begin
        keys_reg <= '0;
      end else begin
        key_cnt_reg <= key_cnt_reg - 16'd1;
      end
    end
  end

  assign bus.keys       = keys_reg;
  assign bus.rotary_pos = rot_reg;
  assign bus.kl         = kl_reg;
  assign bus.trigger    = trig_reg;
  assign bus.cmd_err    = err_reg;

endmodule

// File: tb/tb_cpin.sv
// Testbench for cpin: directed test-plan steps followed by randomized
// command traffic, all compared every cycle against a behavioural model.
module tb_cpin;

  localparam int KEY_CYCLES = 16;
  localparam int TIMEOUT    = 40;

  logic clk_sys;
  logic rst_n;

  cpin_if bus ();

  cpin #(
    .KEY_CYCLES (KEY_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: absolute cycle number and panel expectations
  int          cyc;
  int          key_idx;
  int          key_until;
  int          mode;         // 0 command, 1 waiting high data, 2 waiting low data
  int          last_byte;    // cycle of the last accepted byte in data mode
  logic [7:0]  m_hold;
  logic [15:0] m_kl;
  logic [3:0]  m_rot;
  logic        m_trig;
  logic        m_err;
  logic        saw_err;

  function automatic logic [15:0] exp_keys();
    if (cyc < key_until) return 16'h8000 >> key_idx;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    key_idx   = 0;
    key_until = 0;
    mode      = 0;
    last_byte = 0;
    m_hold    = 8'h00;
    m_kl      = 16'h0000;
    m_rot     = 4'h0;
    m_trig    = 1'b0;
    m_err     = 1'b0;
  endtask

  // Expected outputs after one clock edge with the given input
  task automatic model_step(input logic v, input logic [7:0] b);
    cyc    = cyc + 1;
    m_trig = 1'b0;
    m_err  = 1'b0;
    if (mode != 0) begin
      if (v) begin
        if (mode == 1) begin
          m_hold = b;
          mode   = 2;
        end else begin
          m_kl = {m_hold, b};
          mode = 0;
        end
        last_byte = cyc;
      end else if (cyc - last_byte >= TIMEOUT) begin
        mode  = 0;
        m_err = 1'b1;
      end
    end else if (v) begin
      case (b[7:5])
        3'd0: ;
        3'd1: if (b[4]) m_err = 1'b1; else m_rot = b[3:0];
        3'd2: begin
          if (b[4]) m_err = 1'b1;
          else begin
            key_idx   = int'(b[3:0]);
            key_until = cyc + KEY_CYCLES;
          end
        end
        3'd4: if (b[4:0] == 5'd0) m_trig = 1'b1; else m_err = 1'b1;
        3'd5: begin
          if (b[4:0] == 5'd0) begin
            mode      = 1;
            last_byte = cyc;
          end else m_err = 1'b1;
        end
        default: m_err = 1'b1;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("keys", bus.keys, exp_keys());
    chk("rotary_pos", {12'h000, bus.rotary_pos}, {12'h000, m_rot});
    chk("kl", bus.kl, m_kl);
    chk("trigger", {15'h0000, bus.trigger}, {15'h0000, m_trig});
    chk("cmd_err", {15'h0000, bus.cmd_err}, {15'h0000, m_err});
    if (bus.cmd_err === 1'b1) saw_err = 1'b1;
  endtask

  // One clock: drive inputs, update model at the edge, compare at negedge
  task automatic cycle(input logic v, input logic [7:0] b);
    bus.rx_ready = v;
    bus.rx_byte  = b;
    @(posedge clk_sys);
    model_step(v, b);
    @(negedge clk_sys);
    bus.rx_ready = 1'b0;
    bus.rx_byte  = 8'h00;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  // Reset asserted between edges; reset values must appear immediately
  task automatic mid_reset();
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return {3'b000, r[4:0]};
      1, 2:    return {3'b001, 1'b0, r[3:0]};
      3, 4:    return {3'b010, 1'b0, r[3:0]};
      5:       return 8'h80;
      6:       return 8'hA0;
      8:       return {2'b00, r[5], 1'b1, r[3:0]};
      9:       return {3'b100, r[4:0]};
      default: return r[7:0];
    endcase
  endfunction

  initial begin
    cyc         = 0;
    saw_err     = 1'b0;
    rst_n       = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_byte  = 8'h00;
    model_reset();
    #2;
    check_all();
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Rotary then NOP
    cycle(1'b1, 8'h25);
    chk("plan_rotary5", {12'h000, bus.rotary_pos}, 16'h0005);
    cycle(1'b1, 8'h00);
    idle(2);

    // Key 3, replaced by key 7 on the eighth held cycle
    cycle(1'b1, 8'h43);
    chk("plan_key3", bus.keys, 16'h1000);
    idle(7);
    cycle(1'b1, 8'h47);
    chk("plan_key7", bus.keys, 16'h0100);
    idle(KEY_CYCLES + 2);
    chk("plan_key_off", bus.keys, 16'h0000);

    // Status request and malformed status request
    cycle(1'b1, 8'h80);
    chk("plan_trigger", {15'h0000, bus.trigger}, 16'h0001);
    idle(1);
    cycle(1'b1, 8'h81);
    chk("plan_bad_stat_err", {15'h0000, bus.cmd_err}, 16'h0001);
    chk("plan_bad_stat_trig", {15'h0000, bus.trigger}, 16'h0000);
    idle(1);

    // KL write: data bytes must not be decoded as commands
    cycle(1'b1, 8'hA0);
    cycle(1'b1, 8'h12);
    chk("plan_kl_hold", bus.kl, 16'h0000);
    cycle(1'b1, 8'h34);
    chk("plan_kl1234", bus.kl, 16'h1234);
    idle(2);

    // Partial KL write abandoned by timeout
    cycle(1'b1, 8'hA0);
    cycle(1'b1, 8'h56);
    saw_err = 1'b0;
    for (int i = 0; i < TIMEOUT + 5 && !saw_err; i++) cycle(1'b0, 8'h00);
    chk("plan_timeout_seen", {15'h0000, saw_err}, 16'h0001);
    chk("plan_timeout_kl", bus.kl, 16'h1234);
    cycle(1'b1, 8'h29);
    chk("plan_rotary9", {12'h000, bus.rotary_pos}, 16'h0009);

    // Reset in the middle of a KL write, with a key pulse also running
    cycle(1'b1, 8'h4A);
    cycle(1'b1, 8'hA0);
    cycle(1'b1, 8'hFF);
    mid_reset();
    chk("plan_reset_kl", bus.kl, 16'h0000);
    cycle(1'b1, 8'hA0);
    cycle(1'b1, 8'hAB);
    cycle(1'b1, 8'hCD);
    chk("plan_klABCD", bus.kl, 16'hABCD);

    // Rotary then key on back-to-back cycles
    cycle(1'b1, 8'h2F);
    cycle(1'b1, 8'h40);
    chk("plan_key0", bus.keys, 16'h8000);
    idle(3);

    // Randomized traffic with occasional long gaps and one reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 250) idle(TIMEOUT + 5);
      if (i == 1500) mid_reset();
      if ($urandom_range(0, 2) == 0) cycle(1'b1, rand_byte());
      else cycle(1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
